control_unit: RTL

//  Moore FSM that sequences the 8-bit CPU datapath: fetch/decode/execute over PC, MAR, IR, A, B, R, CCR and ALU.

---
 rtl/control_unit_if.sv | 32 +++
 rtl/control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the 8-bit datapath.
// master = control unit (consumes opcode/flags, drives strobes and selects),
// slave  = datapath side.
interface control_unit_if;
  logic [7:0] ir;
  logic [3:0] ccr_result;   // {N,Z,V,C}
  logic       ir_load;
  logic       mar_load;
  logic       pc_load;
  logic       pc_inc;
  logic       a_load;
  logic       b_load;
  logic       r_load;
  logic       ccr_load;
  logic [2:0] alu_sel;
  logic       alu_opb_sel;
  logic [1:0] bus1_sel;
  logic [1:0] bus2_sel;
  logic       write;

  modport master (
    input  ir, ccr_result,
    output ir_load, mar_load, pc_load, pc_inc, a_load, b_load, r_load, ccr_load,
           alu_sel, alu_opb_sel, bus1_sel, bus2_sel, write
  );

  modport slave (
    output ir, ccr_result,
    input  ir_load, mar_load, pc_load, pc_inc, a_load, b_load, r_load, ccr_load,
           alu_sel, alu_opb_sel, bus1_sel, bus2_sel, write
  );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU: fetch / decode / execute with a wait
// state after every MAR load (synchronous memory read latency of one clk).
// The opcode is captured into op_q in decode so every later state decodes
// its outputs from registers only.
module control_unit #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_OPND_4, S_OPND_5, S_OPND_6, S_OPND_7, S_OPND_8,
    S_EXEC_4, S_BR_4, S_BR_5, S_BR_6, S_NOBR_4, S_HALT
  } state_t;

  localparam logic [7:0] LDA_IMM = 8'h86, LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88, LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96, STB_DIR = 8'h97, STR_DIR = 8'h98;
  localparam logic [7:0] SUB_BA  = 8'h4F;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;

  logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, r_load, ccr_load;
  logic [2:0] alu_sel;
  logic       alu_opb_sel;
  logic [1:0] bus1_sel, bus2_sel;
  logic       write;

  // ALU opcode to alu_sel; valid only when is_alu() is true.
  function automatic logic [2:0] alu_code(input logic [7:0] op);
    case (op)
      8'h42:        alu_code = 3'b000;
      8'h43, 8'h4F: alu_code = 3'b001;
      8'h44:        alu_code = 3'b010;
      8'h45:        alu_code = 3'b011;
      8'h4A:        alu_code = 3'b100;
      8'h4B, 8'h4E: alu_code = 3'b101;
      8'h46, 8'h4C: alu_code = 3'b110;
      default:      alu_code = 3'b111;   // 48 DECA, 4D DECB
    endcase
  endfunction

  function automatic logic is_alu(input logic [7:0] op);
    is_alu = op inside {8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48,
                        8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F};
  endfunction

  // B-destination ALU ops (bus1 = B, result into B).
  function automatic logic is_bop(input logic [7:0] op);
    is_bop = op inside {8'h4C, 8'h4D, 8'h4E, 8'h4F};
  endfunction

  function automatic logic is_opnd(input logic [7:0] op);
    is_opnd = op inside {LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR, STR_DIR};
  endfunction

  // Branch condition from {N,Z,V,C}; 20 is unconditional.
  function automatic logic br_taken(input logic [7:0] op, input logic [3:0] f);
    case (op)
      8'h20:   br_taken = 1'b1;
      8'h21:   br_taken = f[3];
      8'h22:   br_taken = !f[3];
      8'h23:   br_taken = f[2];
      8'h24:   br_taken = !f[2];
      8'h25:   br_taken = f[1];
      8'h26:   br_taken = !f[1];
      8'h27:   br_taken = f[0];
      default: br_taken = !f[0];       // 28 BCC
    endcase
  endfunction

  // State and captured opcode; reset lands directly in fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH_0;
      op_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state and Moore outputs (from state_q/op_q only).
  always_comb begin
    state_d     = S_FETCH_0;
    op_d        = op_q;
    ir_load     = 1'b0;
    mar_load    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    a_load      = 1'b0;
    b_load      = 1'b0;
    r_load      = 1'b0;
    ccr_load    = 1'b0;
    alu_sel     = 3'b000;
    alu_opb_sel = 1'b0;
    bus1_sel    = 2'b00;
    bus2_sel    = 2'b00;
    write       = 1'b0;
    case (state_q)
      S_FETCH_0, S_OPND_4, S_BR_4: begin
        mar_load = 1'b1;
        bus2_sel = 2'b01;
        state_d  = (state_q == S_FETCH_0) ? S_FETCH_1 :
                   (state_q == S_OPND_4)  ? S_OPND_5  : S_BR_5;
      end
      S_FETCH_1: begin
        pc_inc  = 1'b1;
        state_d = S_FETCH_2;
      end
      S_FETCH_2: begin
        ir_load  = 1'b1;
        bus2_sel = 2'b10;
        state_d  = S_DECODE_3;
      end
      S_DECODE_3: begin
        op_d = cu.ir;
        if (is_opnd(cu.ir))                        state_d = S_OPND_4;
        else if (is_alu(cu.ir))                    state_d = S_EXEC_4;
        else if (cu.ir inside {[8'h20:8'h28]})
          state_d = br_taken(cu.ir, cu.ccr_result) ? S_BR_4 : S_NOBR_4;
        else                                       state_d = ILLEGAL_HALT ? S_HALT : S_FETCH_0;
      end
      S_OPND_5: begin
        pc_inc  = 1'b1;
        state_d = S_OPND_6;
      end
      S_OPND_6: begin
        bus2_sel = 2'b10;
        if (op_q == LDA_IMM || op_q == LDB_IMM) begin
          a_load  = (op_q == LDA_IMM);
          b_load  = (op_q == LDB_IMM);
          state_d = S_FETCH_0;
        end else begin
          mar_load = 1'b1;              // operand is an address
          state_d  = S_OPND_7;
        end
      end
      S_OPND_7: begin
        if (op_q inside {STA_DIR, STB_DIR, STR_DIR}) begin
          write    = 1'b1;
          bus1_sel = (op_q == STA_DIR) ? 2'b01 : (op_q == STB_DIR) ? 2'b10 : 2'b11;
          state_d  = S_FETCH_0;
        end else begin
          state_d  = S_OPND_8;          // read wait for direct load
        end
      end
      S_OPND_8: begin
        bus2_sel = 2'b10;
        a_load   = (op_q == LDA_DIR);
        b_load   = (op_q == LDB_DIR);
      end
      S_EXEC_4: begin
        r_load   = 1'b1;
        ccr_load = 1'b1;
        alu_sel  = alu_code(op_q);
        if (is_bop(op_q)) begin
          b_load      = 1'b1;
          bus1_sel    = 2'b10;
          alu_opb_sel = (op_q == SUB_BA);
        end else begin
          a_load   = 1'b1;
          bus1_sel = 2'b01;
        end
      end
      S_BR_5:   state_d = S_BR_6;
      S_BR_6: begin
        bus2_sel = 2'b10;
        pc_load  = 1'b1;
      end
      S_NOBR_4: pc_inc  = 1'b1;          // skip the branch target byte
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH_0;
    endcase
  end

  assign cu.ir_load     = ir_load;
  assign cu.mar_load    = mar_load;
  assign cu.pc_load     = pc_load;
  assign cu.pc_inc      = pc_inc;
  assign cu.a_load      = a_load;
  assign cu.b_load      = b_load;
  assign cu.r_load      = r_load;
  assign cu.ccr_load    = ccr_load;
  assign cu.alu_sel     = alu_sel;
  assign cu.alu_opb_sel = alu_opb_sel;
  assign cu.bus1_sel    = bus1_sel;
  assign cu.bus2_sel    = bus2_sel;
  assign cu.write       = write;

endmodule
